// File: rtl/mua_stream_encoder_pkg.sv
// mua_stream_encoder_pkg: shared defaults, FSM states and the reset codebook table
package mua_stream_encoder_pkg;
  localparam int NCH_DEF = 4;
  localparam int RATE_BITS_DEF = 3;
  localparam int MAX_CW_DEF = 3;
  localparam int LEN_W_DEF = 2;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  function automatic logic [MAX_CW_DEF-1:0] def_code(input int s);
    return s == 0 ? 3'b000 : s == 1 ? 3'b101 : s == 2 ? 3'b110 : s == 3 ? 3'b111 : 3'b100;
  endfunction
  function automatic logic [LEN_W_DEF-1:0] def_len(input int s);
    return s == 0 ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/mua_codebook.sv
// mua_codebook: codeword/length register file with a write port and a combinational read port
module mua_codebook
  import mua_stream_encoder_pkg::*;
#(
  parameter int RATE_BITS = RATE_BITS_DEF,
  parameter int MAX_CW = MAX_CW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [RATE_BITS-1:0] waddr,
  input  logic [MAX_CW-1:0]    wcode,
  input  logic [LEN_W-1:0]     wlen,
  input  logic [RATE_BITS-1:0] raddr,
  output logic [MAX_CW-1:0]    rcode,
  output logic [LEN_W-1:0]     rlen
);
  logic [MAX_CW-1:0] code_mem [2**RATE_BITS];
  logic [LEN_W-1:0] len_mem [2**RATE_BITS];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 2**RATE_BITS; i++) begin
        code_mem[i] <= MAX_CW'(def_code(i));
        len_mem[i] <= LEN_W'(def_len(i));
      end
    else if (we) begin
      code_mem[waddr] <= wcode;
      len_mem[waddr] <= wlen;
    end
  assign rcode = code_mem[raddr];
  assign rlen = len_mem[raddr];
endmodule

// File: rtl/mua_stream_encoder.sv
// mua_stream_encoder: per-channel spike-rate binning serialised as variable-length codewords
module mua_stream_encoder
  import mua_stream_encoder_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int RATE_BITS = RATE_BITS_DEF,
  parameter int MAX_CW = MAX_CW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       spike_in,
  input  logic                 bin_finish,
  input  logic                 cb_we,
  input  logic [RATE_BITS-1:0] cb_addr,
  input  logic [MAX_CW-1:0]    cb_code,
  input  logic [LEN_W-1:0]     cb_len,
  output logic                 out_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_start,
  output logic                 busy,
  output logic                 overflow
);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  state_t state, state_n;
  logic [CH_W-1:0] ch, ch_n;
  logic [MAX_CW-1:0] sr, sr_n, rd_code;
  logic [LEN_W-1:0] left, left_n, rd_len;
  logic first, first_n, accept, last;
  logic [RATE_BITS-1:0] cnt [NCH];
  logic [RATE_BITS-1:0] snap [NCH];
  assign accept = bin_finish & ~busy;
  assign last = ch == CH_W'(NCH - 1);
  mua_codebook #(.RATE_BITS(RATE_BITS), .MAX_CW(MAX_CW), .LEN_W(LEN_W)) u_cb (
    .clk(clk), .rst(rst), .we(cb_we & ~busy), .waddr(cb_addr), .wcode(cb_code), .wlen(cb_len),
    .raddr(snap[ch]), .rcode(rd_code), .rlen(rd_len)
  );
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++)
      if (rst) begin
        cnt[i] <= '0;
        snap[i] <= '0;
      end else begin
        cnt[i] <= bin_finish ? RATE_BITS'(spike_in[i]) :
                  (spike_in[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
        if (accept) snap[i] <= cnt[i];
      end
  always_comb begin
    state_n = state;
    ch_n = ch;
    sr_n = sr;
    left_n = left;
    first_n = first;
    case (state)
      LOAD:
        if (rd_len != '0) begin
          state_n = SHIFT;
          sr_n = rd_code << (MAX_CW - int'(rd_len));
          left_n = rd_len;
        end else begin
          state_n = last ? IDLE : LOAD;
          ch_n = ch + 1'b1;
        end
      SHIFT:
        if (out_valid && out_ready) begin
          first_n = 1'b0;
          sr_n = sr << 1;
          left_n = left - 1'b1;
          if (left == LEN_W'(1)) begin
            state_n = last ? IDLE : LOAD;
            ch_n = ch + 1'b1;
          end
        end
      default:
        if (accept) begin
          state_n = LOAD;
          ch_n = '0;
          first_n = 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      sr <= '0;
      left <= '0;
      first <= 1'b0;
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      sr <= sr_n;
      left <= left_n;
      first <= first_n;
      out_valid <= state_n == SHIFT;
      out_bit <= state_n == SHIFT && sr_n[MAX_CW-1];
      frame_start <= state_n == SHIFT && first_n;
      busy <= accept || state != IDLE;
      overflow <= bin_finish && busy;
    end
endmodule

// File: tb/tb_mua_stream_encoder.sv
// tb_mua_stream_encoder: randomized scoreboard bench against a frame-level reference model
module tb_mua_stream_encoder;
  localparam int NCH = 4;
  localparam int RB = 3;
  localparam int CW = 3;
  localparam int LW = 2;
  logic clk = 1'b0;
  logic rst, bin_finish, cb_we, out_bit, out_valid, out_ready, frame_start, busy, overflow;
  logic [NCH-1:0] spike_in;
  logic [RB-1:0] cb_addr;
  logic [CW-1:0] cb_code;
  logic [LW-1:0] cb_len;
  typedef struct {logic b; logic fs;} exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0, ovf_seen = 0, exp_ovf = 0, rmode = 0, ph = 0;
  int cnt[NCH];
  int cb_c[8];
  int cb_l[8];
  logic [3:0] pat = 4'b1001;
  always #5 clk = ~clk;
  mua_stream_encoder #(.NCH(NCH), .RATE_BITS(RB), .MAX_CW(CW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .bin_finish(bin_finish), .cb_we(cb_we),
    .cb_addr(cb_addr), .cb_code(cb_code), .cb_len(cb_len), .out_bit(out_bit),
    .out_valid(out_valid), .out_ready(out_ready), .frame_start(frame_start),
    .busy(busy), .overflow(overflow)
  );
  task automatic chk(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cb_default;
    cb_c = '{0, 5, 6, 7, 4, 4, 4, 4};
    cb_l = '{1, 3, 3, 3, 3, 3, 3, 3};
  endtask
  task automatic push_frame;
    bit f = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      int s = cnt[c];
      for (int k = cb_l[s] - 1; k >= 0; k--) begin
        exp_t e;
        e.b = cb_c[s][k];
        e.fs = f;
        f = 1'b0;
        sb.push_back(e);
      end
    end
  endtask
  task automatic spikes(input logic [NCH-1:0] v);
    spike_in = v;
    for (int c = 0; c < NCH; c++) if (v[c]) cnt[c] = cnt[c] < 7 ? cnt[c] + 1 : 7;
    tick;
    spike_in = '0;
  endtask
  task automatic bin(input logic [NCH-1:0] v, input bit acc);
    if (acc) push_frame;
    else exp_ovf++;
    for (int c = 0; c < NCH; c++) cnt[c] = int'(v[c]);
    spike_in = v;
    bin_finish = 1'b1;
    tick;
    bin_finish = 1'b0;
    spike_in = '0;
  endtask
  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick;
      n++;
    end
    chk("drain_left", sb.size(), 0);
    sb.delete();
    repeat (NCH + 3) tick;
    chk("idle_busy", busy, 0);
  endtask
  task automatic cbw(input int a, input int c, input int l);
    cb_we = 1'b1;
    cb_addr = RB'(a);
    cb_code = CW'(c);
    cb_len = LW'(l);
    tick;
    cb_we = 1'b0;
    cb_c[a] = c;
    cb_l[a] = l;
  endtask
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : pat[ph % 4];
      ph++;
    end
  end
  always @(negedge clk)
    if (!rst) begin
      if (overflow) ovf_seen++;
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_valid", out_valid, 0);
        else begin
          chk("out_bit", out_bit, sb[0].b);
          chk("frame_start", frame_start, sb[0].fs);
          if (out_ready) void'(sb.pop_front());
        end
      end else if (frame_start) chk("frame_start_no_valid", frame_start, out_valid);
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int n;
    rst = 1'b1;
    spike_in = '0;
    bin_finish = 1'b0;
    cb_we = 1'b0;
    cb_addr = '0;
    cb_code = '0;
    cb_len = '0;
    cb_default;
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    spikes(4'b1110);
    spikes(4'b1100);
    spikes(4'b1000);
    bin(4'b0000, 1'b1);
    chk("busy_t1", busy, 1);
    chk("valid_t1", out_valid, 0);
    tick;
    chk("valid_t2", out_valid, 1);
    chk("fs_t2", frame_start, 1);
    drain;
    repeat (9) spikes(4'b0001);
    bin(4'b0000, 1'b1);
    drain;
    rmode = 2;
    spikes(4'b1110);
    spikes(4'b0100);
    bin(4'b0000, 1'b1);
    drain;
    rmode = 0;
    repeat (3) spikes(4'b1111);
    bin(4'b0000, 1'b1);
    repeat (4) tick;
    chk("busy_mid_frame", busy, 1);
    spikes(4'b0100);
    bin(4'b0010, 1'b0);
    spikes(4'b0001);
    drain;
    bin(4'b0000, 1'b1);
    drain;
    cbw(0, 0, 0);
    bin(4'b0000, 1'b1);
    cb_we = 1'b1;
    cb_addr = 3'd1;
    cb_code = '0;
    cb_len = '0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) n++;
      tick;
      cb_we = 1'b0;
    end
    chk("busy_zero_len", n, NCH + 1);
    cbw(0, 0, 1);
    spikes(4'b0001);
    bin(4'b0000, 1'b1);
    drain;
    bin(4'b0010, 1'b1);
    drain;
    bin(4'b0000, 1'b1);
    drain;
    repeat (3) spikes(4'b1111);
    bin(4'b0000, 1'b1);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    sb.delete();
    tick;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    cb_default;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (10) tick;
    for (int it = 0; it < 30; it++) begin
      rmode = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) cbw(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 15)) spikes(NCH'($urandom));
      bin(NCH'($urandom), 1'b1);
      drain;
    end
    rmode = 0;
    chk("overflow_pulses", ovf_seen, exp_ovf);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
